// File: rtl/free_list.sv
// Circular free list of physical register indices with per-branch read-pointer checkpoints.
// Define FREE_LIST_BYPASS_EN for a same-cycle enqueue-to-dequeue path when empty.
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int NUM_TAGS  = 4,
  localparam int DEPTH  = NUM_PREGS - NUM_AREGS,
  localparam int TAG_W  = $clog2(NUM_TAGS),
  localparam int PREG_W = $clog2(NUM_PREGS),
  localparam int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [PREG_W-1:0] wdata,
  output logic              full,
  input  logic              ren,
  output logic [PREG_W-1:0] rdata,
  output logic              empty,
  output logic [PTR_W-1:0]  count,
  input  logic              ckpt_en,
  input  logic [TAG_W-1:0]  ckpt_tag,
  input  logic              broadcast,
  input  logic              kill,
  input  logic [TAG_W-1:0]  tag
);

  localparam int IDX_W = PTR_W - 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("free_list: DEPTH must be a power of two");
  end

  logic [PREG_W-1:0] mem  [DEPTH];
  logic [PTR_W-1:0]  ckpt [NUM_TAGS];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_nxt;
  logic              restore;
  logic              byp;
  logic              do_enq;
  logic              do_deq;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == PTR_W'(DEPTH));
  assign empty   = (count == '0);
  assign restore = broadcast & kill;

`ifdef FREE_LIST_BYPASS_EN
  assign byp = empty & wen & ren & ~restore;
`else
  assign byp = 1'b0;
`endif

  // a bypassed entry is consumed in flight and never stored
  assign do_enq = wen & ~full & ~byp;
  assign do_deq = ren & ~empty & ~restore;
  assign rd_nxt = rd_ptr + PTR_W'(do_deq);
  assign rdata  = byp ? wdata : mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= PREG_W'(NUM_AREGS + i);
      for (int i = 0; i < NUM_TAGS; i++)
        ckpt[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= PTR_W'(DEPTH);
    end else begin
      if (do_enq) begin
        mem[wr_ptr[IDX_W-1:0]] <= wdata;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (restore) begin
        rd_ptr <= ckpt[tag];
      end else begin
        rd_ptr <= rd_nxt;
        if (ckpt_en)
          ckpt[ckpt_tag] <= rd_nxt;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && restore)
      assert (PTR_W'(wr_ptr + PTR_W'(do_enq) - ckpt[tag]) <= PTR_W'(DEPTH))
      else $error("free_list: restore overflows occupancy");
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Randomized scoreboard bench for free_list against a sequence-number model.
module tb_free_list;

  localparam int NA    = 32;
  localparam int NT    = 4;
  localparam int DEPTH = 32;
  localparam int PW    = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic       ckpt_en = 1'b0;
  logic       broadcast = 1'b0;
  logic       kill = 1'b0;
  logic [5:0] wdata = '0;
  logic [1:0] ckpt_tag = '0;
  logic [1:0] tag = '0;
  logic       full;
  logic       empty;
  logic [5:0] rdata;
  logic [5:0] count;

  free_list dut (
    .clk(clk), .rst(rst),
    .wen(wen), .wdata(wdata), .full(full),
    .ren(ren), .rdata(rdata), .empty(empty), .count(count),
    .ckpt_en(ckpt_en), .ckpt_tag(ckpt_tag),
    .broadcast(broadcast), .kill(kill), .tag(tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit emp;
    bit ful;
    int rd;
    bit rv;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  // absolute sequence model: hist[n] is the n-th register ever queued
  int   hist[int];
  int   head;
  int   tail;
  int   ck[NT];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist[i] = NA + i;
    head = 0;
    tail = DEPTH;
    for (int i = 0; i < NT; i++) ck[i] = 0;
  endtask

  task automatic idle();
    wen = 0; ren = 0; ckpt_en = 0;
    broadcast = 0; kill = 0;
    wdata = '0; ckpt_tag = '0; tag = '0;
  endtask

  task automatic cycle(bit w, int wd, bit r, bit ce = 0, int ct = 0,
                       bit b = 0, bit k = 0, int t = 0);
    exp_t e;
    int cnt;
    int nh;
    bit rs, byp, enq, deq;
    @(negedge clk);
    wen = w; wdata = 6'(wd); ren = r;
    ckpt_en = ce; ckpt_tag = 2'(ct);
    broadcast = b; kill = k; tag = 2'(t);
    cnt = tail - head;
    rs  = b && k;
    byp = 0;
`ifdef FREE_LIST_BYPASS_EN
    byp = (cnt == 0) && w && r && !rs;
`endif
    enq = w && (cnt != DEPTH) && !byp;
    deq = r && (cnt != 0) && !rs;
    if (byp) begin
      #1;
      chk("bypass_rdata", rdata, wd);
    end
    if (enq) begin
      hist[tail] = wd;
      tail++;
    end
    nh = head + (deq ? 1 : 0);
    if (rs) head = ck[t];
    else begin
      if (ce) ck[ct] = nh;
      head = nh;
    end
    e.cnt = tail - head;
    e.emp = (e.cnt == 0);
    e.ful = (e.cnt == DEPTH);
    e.rv  = !e.emp;
    e.rd  = e.rv ? hist[head] : 0;
    sb.push_back(e);
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_count", count, 32);
    chk("rst_full", full, 1);
    chk("rst_empty", empty, 0);
    chk("rst_rdata", rdata, 32);
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        me = sb.pop_front();
        chk("sb_count", count, me.cnt);
        chk("sb_empty", empty, me.emp);
        chk("sb_full", full, me.ful);
        if (me.rv) chk("sb_rdata", rdata, me.rd);
      end
    end
  end

  initial begin
    int pw, pr, cnt, ta, t;
    bit w, r, b, k;
    idle();
    model_reset();
    #12;
    chk("init_count", count, 32);
    chk("init_full", full, 1);
    chk("init_empty", empty, 0);
    chk("init_rdata", rdata, 32);
    @(negedge clk);
    rst = 1;

    cycle(1, 5, 0);
    chk("drop_count", count, 32);
    chk("drop_rdata", rdata, 32);
    cycle(1, 9, 1);
    chk("full_wr_rd_count", count, 31);
    chk("full_wr_rd_rdata", rdata, 33);

    do_reset();
    repeat (3) cycle(0, 0, 1);
    cycle(0, 0, 0, 1, 2);
    chk("ckpt2", dut.ckpt[2], 3);
    for (int i = 0; i < 4; i++) begin
      chk("pre_restore_rdata", rdata, 35 + i);
      cycle(0, 0, 1);
    end
    cycle(1, 50, 1, 1, 1, 1, 1, 2);
    chk("restore_rdata", rdata, 35);
    chk("restore_count", count, 30);
    chk("restore_ckpt1", dut.ckpt[1], 0);

    do_reset();
    for (int i = 0; i < 32; i++) begin
      chk("drain_rdata", rdata, 32 + i);
      cycle(0, 0, 1);
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    cycle(1, 7, 1);
`ifdef FREE_LIST_BYPASS_EN
    chk("byp_count", count, 0);
`else
    chk("nobyp_count", count, 1);
    chk("nobyp_rdata", rdata, 7);
`endif
    while (tail - head > 0) cycle(0, 0, 1);

    for (int i = 0; i < 3; i++) cycle(1, 40 + i, 0);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_rdata", rdata, 40 + i);
      cycle(0, 0, 1);
    end
    chk("wrap_rd_msb", dut.rd_ptr[PW-1], 1);
    chk("wrap_wr_msb", dut.wr_ptr[PW-1], 1);

    for (int n = 0; n < 3000; n++) begin
      case ((n / 300) % 3)
        0: begin pw = 75; pr = 30; end
        1: begin pw = 30; pr = 75; end
        default: begin pw = 55; pr = 55; end
      endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      w   = $urandom_range(0, 99) < pw;
      r   = $urandom_range(0, 99) < pr;
      b   = $urandom_range(0, 4) == 0;
      k   = b && ($urandom_range(0, 1) == 1);
      t   = $urandom_range(0, NT - 1);
      cnt = tail - head;
      ta  = tail + ((w && cnt < DEPTH) ? 1 : 0);
      if (k && ((ta - ck[t]) < 0 || (ta - ck[t]) > DEPTH)) k = 0;
      cycle(w, $urandom_range(0, 63), r, $urandom_range(0, 3) == 0,
            $urandom_range(0, NT - 1), b, k, t);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
